// File: rtl/waterfall_pkg.sv
// Shared types and constants for the waterfall LED front end: FSM state encoding
// and the 2-bit speed codes understood by the waterfall shifter.
package waterfall_pkg;

  localparam int FREQ_W = 2;

  localparam logic [FREQ_W-1:0] FREQ_1X  = 2'b00;
  localparam logic [FREQ_W-1:0] FREQ_2X  = 2'b01;
  localparam logic [FREQ_W-1:0] FREQ_5X  = 2'b10;
  localparam logic [FREQ_W-1:0] FREQ_10X = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RELOAD = 2'd2,
    RESUME = 2'd3
  } wf_in_state_t;

endpackage

// File: rtl/input_debounce.sv
// 2-FF synchronizer followed by a counting debouncer; a WIDTH-bit vector is
// accepted only after CYCLES consecutive cycles of disagreeing with the stable value.
module input_debounce #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int CW = $clog2(CYCLES + 1);
  // The register holds mismatches already counted, so the CYCLES-th one is seen at CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/waterfall_input.sv
// Button/switch front end for waterfall: debounces inputs, pulses start, sequences a
// soft reset on speed change. WATERFALL_INPUT_AUTO_RESUME_EN restarts the pattern afterwards.
module waterfall_input
  import waterfall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int RST_HOLD        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic [FREQ_W-1:0] sw_freq,
  output logic              start,
  output logic [FREQ_W-1:0] freq_set,
  output logic              soft_rst,
  output logic              running
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD);

  logic              w_btn_stable;
  logic [FREQ_W-1:0] w_sw_stable;
  logic              r_btn_q;
  logic              w_press;
  logic              w_chg;

  wf_in_state_t      r_state, w_state_nxt;
  logic              r_start, w_start_nxt;
  logic [FREQ_W-1:0] r_freq_set, w_freq_nxt;
  logic              r_soft_rst, w_soft_rst_nxt;
  logic              r_running, w_running_nxt;
  logic [HW-1:0]     r_hold_cnt, w_hold_nxt;
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
  logic              r_was_run, w_was_run_nxt;
`endif

  input_debounce #(
    .WIDTH  (1),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (btn_start),
    .o_stable (w_btn_stable)
  );

  input_debounce #(
    .WIDTH  (FREQ_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (sw_freq),
    .o_stable (w_sw_stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btn_q <= 1'b0;
    else     r_btn_q <= w_btn_stable;
  end

  assign w_press = w_btn_stable & ~r_btn_q;
  // Level compare against the applied code, so a change arriving mid-reload is still seen later.
  assign w_chg   = (w_sw_stable != r_freq_set);

  always_comb begin
    w_state_nxt    = r_state;
    w_start_nxt    = 1'b0;
    w_freq_nxt     = r_freq_set;
    w_soft_rst_nxt = r_soft_rst;
    w_running_nxt  = r_running;
    w_hold_nxt     = r_hold_cnt;
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
    w_was_run_nxt  = r_was_run;
`endif
    case (r_state)
      IDLE: begin
        if (w_chg) begin
          w_state_nxt    = RELOAD;
          w_freq_nxt     = w_sw_stable;
          w_soft_rst_nxt = 1'b1;
          w_running_nxt  = 1'b0;
          w_hold_nxt     = HW'(1);
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
          w_was_run_nxt  = 1'b0;
`endif
        end else if (w_press) begin
          w_state_nxt   = RUN;
          w_start_nxt   = 1'b1;
          w_running_nxt = 1'b1;
        end
      end
      RUN: begin
        if (w_chg) begin
          w_state_nxt    = RELOAD;
          w_freq_nxt     = w_sw_stable;
          w_soft_rst_nxt = 1'b1;
          w_running_nxt  = 1'b0;
          w_hold_nxt     = HW'(1);
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
          w_was_run_nxt  = 1'b1;
`endif
        end
      end
      RELOAD: begin
        if (r_hold_cnt >= HOLD_LAST) begin
          w_soft_rst_nxt = 1'b0;
          w_hold_nxt     = '0;
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
          w_state_nxt    = r_was_run ? RESUME : IDLE;
`else
          w_state_nxt    = IDLE;
`endif
        end else begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
      RESUME: begin
        w_state_nxt   = RUN;
        w_start_nxt   = 1'b1;
        w_running_nxt = 1'b1;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_start    <= 1'b0;
      r_freq_set <= FREQ_1X;
      r_soft_rst <= 1'b0;
      r_running  <= 1'b0;
      r_hold_cnt <= '0;
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
      r_was_run  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_start    <= w_start_nxt;
      r_freq_set <= w_freq_nxt;
      r_soft_rst <= w_soft_rst_nxt;
      r_running  <= w_running_nxt;
      r_hold_cnt <= w_hold_nxt;
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
      r_was_run  <= w_was_run_nxt;
`endif
    end
  end

  assign start    = r_start;
  assign freq_set = r_freq_set;
  assign soft_rst = r_soft_rst;
  assign running  = r_running;

endmodule

// File: tb/tb_waterfall_input.sv
// Directed bench for waterfall_input with DEBOUNCE_CYCLES=8, RST_HOLD=4.
module tb_waterfall_input;
  import waterfall_pkg::*;

  localparam int DB    = 8;
  localparam int HOLD  = 4;
  localparam int T_LAT = DB + 3;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic [1:0] sw_freq;
  logic       start;
  logic [1:0] freq_set;
  logic       soft_rst;
  logic       running;

  int n_checks;
  int n_fail;

  waterfall_input #(
    .DEBOUNCE_CYCLES (DB),
    .RST_HOLD        (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .sw_freq   (sw_freq),
    .start     (start),
    .freq_set  (freq_set),
    .soft_rst  (soft_rst),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b1;
    btn_start = 1'b0;
    sw_freq   = FREQ_1X;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic go_run();
    btn_start = 1'b1;
    repeat (T_LAT + 1) @(negedge clk);
    btn_start = 1'b0;
    repeat (T_LAT + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    btn_start = 1'b0;
    sw_freq   = FREQ_1X;
    #1;
    n_checks++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
    n_checks++;
    if (freq_set !== 2'b00) begin n_fail++; $display("FAIL reset_freq_set: got %b want 00", freq_set); end
    n_checks++;
    if (soft_rst !== 1'b0) begin n_fail++; $display("FAIL reset_soft_rst: got %b want 0", soft_rst); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({start, freq_set, soft_rst, running} !== 5'b0) begin
      n_fail++; $display("FAIL reset_idle_quiet: got %b want 00000", {start, freq_set, soft_rst, running});
    end
  endtask

  task automatic test_start();
    int start_at, start_cnt, soft_cnt, extra;
    start_at = -1; start_cnt = 0; soft_cnt = 0; extra = 0;
    do_reset();
    btn_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (start) begin start_cnt++; start_at = k; end
      if (soft_rst) soft_cnt++;
    end
    n_checks++;
    if (start_cnt != 1) begin n_fail++; $display("FAIL start_count: got %0d want 1", start_cnt); end
    n_checks++;
    if (start_at != T_LAT) begin n_fail++; $display("FAIL start_latency: got %0d want %0d", start_at, T_LAT); end
    n_checks++;
    if (soft_cnt != 0) begin n_fail++; $display("FAIL start_no_soft_rst: got %0d cycles want 0", soft_cnt); end
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b want 1", running); end
    // Release (falling edge) then press again while running: both must be ignored.
    btn_start = 1'b0;
    repeat (15) begin @(negedge clk); if (start) extra++; end
    btn_start = 1'b1;
    repeat (15) begin @(negedge clk); if (start) extra++; end
    btn_start = 1'b0;
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL start_ignored_in_run: got %0d pulses want 0", extra); end
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL start_still_running: got %b want 1", running); end
  endtask

  task automatic test_glitch();
    int start_cnt, run_cnt, start_at;
    start_cnt = 0; run_cnt = 0; start_at = -1;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      btn_start = 1'b1;
      repeat (5) begin @(negedge clk); if (start) start_cnt++; if (running) run_cnt++; end
      btn_start = 1'b0;
      repeat (5) begin @(negedge clk); if (start) start_cnt++; if (running) run_cnt++; end
    end
    repeat (5) begin @(negedge clk); if (start) start_cnt++; if (running) run_cnt++; end
    n_checks++;
    if (start_cnt != 0) begin n_fail++; $display("FAIL glitch_start: got %0d pulses want 0", start_cnt); end
    n_checks++;
    if (run_cnt != 0) begin n_fail++; $display("FAIL glitch_running: got %0d cycles want 0", run_cnt); end
    btn_start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (start && start_at < 0) start_at = k;
    end
    btn_start = 1'b0;
    n_checks++;
    if (start_at != T_LAT) begin n_fail++; $display("FAIL glitch_then_press: got %0d want %0d", start_at, T_LAT); end
  endtask

  task automatic test_reload();
    int rise_at, last_hi, hi_cnt, start_at, start_cnt;
    logic [1:0] f_first, f_before;
    logic run_at_rise;
    rise_at = -1; last_hi = -1; hi_cnt = 0; start_at = -1; start_cnt = 0;
    f_first = 2'bxx; f_before = 2'bxx; run_at_rise = 1'bx;
    do_reset();
    go_run();
    sw_freq = FREQ_5X;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == T_LAT - 1) f_before = freq_set;
      if (soft_rst) begin
        hi_cnt++;
        last_hi = k;
        if (rise_at < 0) begin rise_at = k; f_first = freq_set; run_at_rise = running; end
      end
      if (start) begin start_cnt++; start_at = k; end
    end
    n_checks++;
    if (f_before !== 2'b00) begin n_fail++; $display("FAIL reload_freq_before: got %b want 00", f_before); end
    n_checks++;
    if (rise_at != T_LAT) begin n_fail++; $display("FAIL reload_rise: got %0d want %0d", rise_at, T_LAT); end
    n_checks++;
    if (hi_cnt != HOLD || last_hi != T_LAT + HOLD - 1) begin
      n_fail++; $display("FAIL reload_hold: got %0d cycles ending %0d want %0d ending %0d", hi_cnt, last_hi, HOLD, T_LAT + HOLD - 1);
    end
    n_checks++;
    if (f_first !== 2'b10) begin n_fail++; $display("FAIL reload_freq_first: got %b want 10", f_first); end
    n_checks++;
    if (run_at_rise !== 1'b0) begin n_fail++; $display("FAIL reload_running_drop: got %b want 0", run_at_rise); end
`ifdef WATERFALL_INPUT_AUTO_RESUME_EN
    n_checks++;
    if (start_cnt != 1 || start_at != T_LAT + HOLD + 1) begin
      n_fail++; $display("FAIL resume_start: got %0d pulses at %0d want 1 at %0d", start_cnt, start_at, T_LAT + HOLD + 1);
    end
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b want 1", running); end
`else
    n_checks++;
    if (start_cnt != 0) begin n_fail++; $display("FAIL noresume_start: got %0d pulses want 0", start_cnt); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL noresume_running: got %b want 0", running); end
`endif
  endtask

  task automatic test_freeze();
    int bad_freeze, rise2_at;
    logic prev_soft;
    logic [1:0] f_after, f_rise2;
    bad_freeze = 0; rise2_at = -1; prev_soft = 1'b0; f_after = 2'bxx; f_rise2 = 2'bxx;
    do_reset();
    go_run();
    sw_freq = FREQ_5X;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= T_LAT && k <= T_LAT + HOLD && freq_set !== 2'b10) bad_freeze++;
      if (k == T_LAT + HOLD) f_after = freq_set;
      if (soft_rst && !prev_soft && k > T_LAT && rise2_at < 0) begin rise2_at = k; f_rise2 = freq_set; end
      prev_soft = soft_rst;
      if (k == T_LAT + 1) sw_freq = FREQ_10X;
    end
    n_checks++;
    if (bad_freeze != 0) begin n_fail++; $display("FAIL freeze_during_reload: got %0d bad cycles want 0", bad_freeze); end
    n_checks++;
    if (f_after !== 2'b10) begin n_fail++; $display("FAIL freeze_after_fall: got %b want 10", f_after); end
    n_checks++;
    if (rise2_at != 2 * T_LAT + 1) begin n_fail++; $display("FAIL freeze_second_rise: got %0d want %0d", rise2_at, 2 * T_LAT + 1); end
    n_checks++;
    if (f_rise2 !== 2'b11) begin n_fail++; $display("FAIL freeze_second_freq: got %b want 11", f_rise2); end
  endtask

  task automatic test_simul_rst();
    int start_cnt, rise_at, hi_cnt;
    logic soft_before;
    start_cnt = 0; rise_at = -1; hi_cnt = 0; soft_before = 1'b0;
    do_reset();
    btn_start = 1'b1;
    sw_freq   = FREQ_2X;
    for (int k = 1; k <= T_LAT + 1; k++) begin
      @(negedge clk);
      if (start) start_cnt++;
      if (soft_rst && rise_at < 0) rise_at = k;
    end
    soft_before = soft_rst;
    n_checks++;
    if (rise_at != T_LAT || soft_before !== 1'b1) begin
      n_fail++; $display("FAIL simul_reload: got rise %0d soft %b want rise %0d soft 1", rise_at, soft_before, T_LAT);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({start, freq_set, soft_rst, running} !== 5'b0) begin
      n_fail++; $display("FAIL midreload_rst: got %b want 00000", {start, freq_set, soft_rst, running});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (start) start_cnt++;
      if (soft_rst) hi_cnt++;
    end
    n_checks++;
    if (start_cnt != 0) begin n_fail++; $display("FAIL simul_no_start: got %0d pulses want 0", start_cnt); end
    n_checks++;
    if (hi_cnt != HOLD) begin n_fail++; $display("FAIL simul_rereload: got %0d cycles want %0d", hi_cnt, HOLD); end
    n_checks++;
    if (running !== 1'b0 || freq_set !== FREQ_2X) begin
      n_fail++; $display("FAIL simul_final: got running %b freq %b want 0 01", running, freq_set);
    end
    btn_start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    btn_start = 1'b0;
    sw_freq   = FREQ_1X;
    test_reset();
    test_start();
    test_glitch();
    test_reload();
    test_freeze();
    test_simul_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
